// File: rtl/mem_sram_ctrl.sv
// rtl/mem_sram_ctrl.sv - 32-bit load/store port onto a 16-bit asynchronous SRAM
// Each word is moved as two timed half-accesses (LO then HI) while the pipeline is frozen.
module mem_sram_ctrl #(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] DATA_BASE   = 32'd1024,
  parameter int          SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_r_en,
  input  logic               mem_w_en,
  input  logic [31:0]        alu_res,
  input  logic [31:0]        val_rm,
  output logic               ready,
  output logic [31:0]        read_data,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_we_n
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LO   = 2'd1;
  localparam logic [1:0] HI   = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

  logic [1:0]         state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               wr_q, wr_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
  logic [15:0]        dq_out_q, dq_out_d;
  logic               dq_oe_q, dq_oe_d;
  logic               we_n_q, we_n_d;
  logic [SRAM_AW-2:0] idx_d;
  logic               req, phase_d;

  assign req = mem_r_en | mem_w_en;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = alu_res;
          wdata_d = val_rm;
          wr_d    = mem_w_en;
          state_d = LO;
          cnt_d   = 4'd0;
        end
      end
      LO: begin
        if (cnt_q == LAST) begin
          if (!wr_q) rdata_d[15:0] = sram_dq_in;
          state_d = HI;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      HI: begin
        if (cnt_q == LAST) begin
          if (!wr_q) rdata_d[31:16] = sram_dq_in;
          state_d = DONE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Bus outputs are registered from the next state so they change cleanly on the clock edge.
  always_comb begin
    idx_d       = (SRAM_AW-1)'((addr_d - DATA_BASE) >> 2);
    phase_d     = (state_d == LO) || (state_d == HI);
    sram_addr_d = sram_addr_q;
    dq_out_d    = dq_out_q;
    if (state_d == LO) begin
      sram_addr_d = {idx_d, 1'b0};
      if (wr_d) dq_out_d = wdata_d[15:0];
    end else if (state_d == HI) begin
      sram_addr_d = {idx_d, 1'b1};
      if (wr_d) dq_out_d = wdata_d[31:16];
    end
    dq_oe_d = wr_d && phase_d;
    we_n_d  = !(wr_d && phase_d && (cnt_d != LAST));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      wr_q        <= 1'b0;
      rdata_q     <= 32'd0;
      sram_addr_q <= '0;
      dq_out_q    <= 16'd0;
      dq_oe_q     <= 1'b0;
      we_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wr_q        <= wr_d;
      rdata_q     <= rdata_d;
      sram_addr_q <= sram_addr_d;
      dq_out_q    <= dq_out_d;
      dq_oe_q     <= dq_oe_d;
      we_n_q      <= we_n_d;
    end
  end

  assign ready       = (state_q == DONE) || ((state_q == IDLE) && !req);
  assign read_data   = rdata_q;
  assign sram_addr   = sram_addr_q;
  assign sram_dq_out = dq_out_q;
  assign sram_dq_oe  = dq_oe_q;
  assign sram_we_n   = we_n_q;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// tb/tb_mem_sram_ctrl.sv - scoreboard bench for mem_sram_ctrl with a small SRAM model
module tb_mem_sram_ctrl;
  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_r_en = 1'b0, mem_w_en = 1'b0;
  logic [31:0] alu_res = 32'd0, val_rm = 32'd0;
  logic        ready;
  logic [31:0] read_data;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n;

  mem_sram_ctrl #(.WAIT_CYCLES(W), .DATA_BASE(32'd1024), .SRAM_AW(18)) dut (
    .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .alu_res(alu_res), .val_rm(val_rm), .ready(ready), .read_data(read_data),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:63];
  assign sram_dq_in = mem[sram_addr[5:0]];
  always @(posedge clk) if (!sram_we_n && sram_dq_oe) mem[sram_addr[5:0]] <= sram_dq_out;

  typedef struct {
    logic [31:0] rd;
    logic [17:0] lo;
    logic        wr;
    logic [31:0] d;
  } exp_t;
  exp_t exp_q[$];

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Monitor: records each ready-low run and checks it against the oldest expected access at DONE.
  int          low_n = 0;
  logic [17:0] r_addr [0:15];
  logic        r_we   [0:15];
  logic        r_oe   [0:15];
  logic [15:0] r_dq   [0:15];
  always @(negedge clk) begin
    if (!rst) begin
      low_n = 0;
    end else if (!ready) begin
      if (low_n < 16) begin
        r_addr[low_n] = sram_addr;
        r_we[low_n]   = sram_we_n;
        r_oe[low_n]   = sram_dq_oe;
        r_dq[low_n]   = sram_dq_out;
      end
      low_n++;
    end else if (low_n > 0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_completion", 32'(low_n), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("ready_low_cycles", 32'(low_n), 32'(2*W+1));
        for (int k = 1; k <= 2*W && k < 16; k++) begin
          int p, pos;
          p   = (k - 1) / W;
          pos = (k - 1) % W;
          chk($sformatf("sram_addr[k=%0d]", k), 32'(r_addr[k]), 32'(e.lo + 18'(p)));
          chk($sformatf("sram_we_n[k=%0d]", k), 32'(r_we[k]), 32'(!(e.wr && pos != W-1)));
          chk($sformatf("sram_dq_oe[k=%0d]", k), 32'(r_oe[k]), 32'(e.wr));
          if (e.wr)
            chk($sformatf("sram_dq_out[k=%0d]", k), 32'(r_dq[k]),
                32'(p == 0 ? e.d[15:0] : e.d[31:16]));
        end
        chk("read_data_done", read_data, e.rd);
      end
      low_n = 0;
    end
  end

  task automatic wait_done();
    int i;
    for (i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready) break;
    end
    if (i == 40) chk("timeout_ready", 32'(ready), 32'd1);
  endtask

  task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [17:0] lo, input logic [31:0] exp_rd, input bit jam);
    exp_q.push_back('{rd: exp_rd, lo: lo, wr: w, d: d});
    @(posedge clk); #1;
    mem_r_en = r; mem_w_en = w; alu_res = a; val_rm = d;
    @(posedge clk); #1;
    mem_r_en = 1'b0; mem_w_en = 1'b0;
    if (jam) begin
      alu_res = 32'd2048;
      val_rm  = 32'hFFFF_0000;
      mem_w_en = 1'b1;
    end
    wait_done();
    mem_w_en = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_read_data", read_data, 32'd0);
    chk("reset_sram_addr", 32'(sram_addr), 32'd0);
    chk("reset_we_n", 32'(sram_we_n), 32'd1);
    chk("reset_oe", 32'(sram_dq_oe), 32'd0);
    chk("reset_dq_out", 32'(sram_dq_out), 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(ready), 32'd1);

    access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 18'd2, 32'h0000_0000, 1'b0);
    access(1'b1, 1'b0, 32'd1028, 32'h0,        18'd2, 32'hDEADBEEF, 1'b0);
    access(1'b1, 1'b1, 32'd1024, 32'h12345678, 18'd0, 32'hDEADBEEF, 1'b0);
    access(1'b1, 1'b0, 32'd1024, 32'h0,        18'd0, 32'h12345678, 1'b0);
    access(1'b0, 1'b1, 32'd1032, 32'hCAFEF00D, 18'd4, 32'h12345678, 1'b0);
    access(1'b1, 1'b0, 32'd1032, 32'h0,        18'd4, 32'hCAFEF00D, 1'b1);
    chk("mem_2048_untouched", 32'(mem[0]), 32'h5678);

    // Store to 1036 aborted by reset during HI: only the LO half reaches the SRAM.
    @(posedge clk); #1;
    mem_w_en = 1'b1; alu_res = 32'd1036; val_rm = 32'h1111_2222;
    @(posedge clk); #1 mem_w_en = 1'b0;
    @(posedge clk);
    @(posedge clk); #3 rst = 1'b0;
    #1;
    chk("abort_we_n", 32'(sram_we_n), 32'd1);
    chk("abort_oe", 32'(sram_dq_oe), 32'd0);
    chk("abort_sram_addr", 32'(sram_addr), 32'd0);
    chk("abort_dq_out", 32'(sram_dq_out), 32'd0);
    chk("abort_read_data", read_data, 32'd0);
    chk("abort_ready", 32'(ready), 32'd1);
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    access(1'b1, 1'b0, 32'd1036, 32'h0, 18'd6, 32'h0000_2222, 1'b0);

    // Back-to-back loads with mem_r_en held through DONE.
    exp_q.push_back('{rd: 32'h12345678, lo: 18'd0, wr: 1'b0, d: 32'h0});
    exp_q.push_back('{rd: 32'hDEADBEEF, lo: 18'd2, wr: 1'b0, d: 32'h0});
    @(posedge clk); #1;
    mem_r_en = 1'b1; alu_res = 32'd1024;
    wait_done();
    alu_res = 32'd1028;
    @(negedge clk);
    chk("b2b_ready_second_idle", 32'(ready), 32'd0);
    wait_done();
    @(posedge clk); #1 mem_r_en = 1'b0;
    repeat (6) @(negedge clk);
    chk("b2b_ready_idle", 32'(ready), 32'd1);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/mem_sram_ctrl.md
MEM_SRAM_CTRL -- requirements
Module: mem_sram_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, number of clock cycles each 16-bit SRAM half-access is held (legal range 1..15).
REQ-002 Parameter DATA_BASE, default 32'd1024, byte address that maps to SRAM word 0.
REQ-003 Parameter SRAM_AW, default 18, SRAM address width in 16-bit units.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 mem_r_en  input  1  load request from the EXE/MEM register.
REQ-007 mem_w_en  input  1  store request from the EXE/MEM register.
REQ-008 alu_res  input  32  byte address of the access.
REQ-009 val_rm  input  32  store data.
REQ-010 ready  output  1  high = access complete or no access pending; low = pipeline SHALL freeze.
REQ-011 read_data  output  32  last loaded word, to MEM/WB register.
REQ-012 sram_addr  output  SRAM_AW  SRAM half-word address.
REQ-013 sram_dq_out  output  16  SRAM write data.
REQ-014 sram_dq_oe  output  1  drive-enable for sram_dq_out onto the shared data bus.
REQ-015 sram_dq_in  input  16  SRAM read data.
REQ-016 sram_we_n  output  1  SRAM write strobe, active-low.

Function
REQ-017 FSM states IDLE, LO, HI, DONE, encoded in registers.
REQ-018 IDLE: if mem_w_en or mem_r_en is high, latch alu_res, val_rm and direction at the rising edge, then go to LO; otherwise stay in IDLE.
REQ-019 mem_w_en and mem_r_en both high: the access is a write.
REQ-020 Word index = (latched_addr - DATA_BASE) >> 2, truncated to SRAM_AW-1 bits (wraps silently); alu_res[1:0] ignored.
REQ-021 LO: sram_addr = {index, 1'b0}; HI: sram_addr = {index, 1'b1}; IDLE/DONE: sram_addr holds its last value.
REQ-022 Each of LO and HI lasts exactly WAIT_CYCLES cycles, timed by a counter cleared on every state entry.
REQ-023 Write in LO/HI: sram_we_n = 0, sram_dq_oe = 1, sram_dq_out = val_rm[15:0] in LO and val_rm[31:16] in HI; sram_we_n returns to 1 on the last cycle of each phase, so every write strobe has a rising edge.
REQ-024 Read in LO/HI: sram_we_n = 1, sram_dq_oe = 0; sram_dq_in is sampled on the last cycle of the phase into read_data[15:0] (LO) or read_data[31:16] (HI).
REQ-025 HI then goes to DONE; DONE lasts one cycle and then goes to IDLE unconditionally; a request present in DONE is not accepted.
REQ-026 ready = 1 in DONE, or in IDLE with no request pending; ready = 0 otherwise, including the IDLE cycle where a request is first seen (combinational).
REQ-027 Latency: a request first seen in cycle t holds ready low for cycles t..t+2*WAIT_CYCLES, and ready is high in cycle t+2*WAIT_CYCLES+1 (DONE).
REQ-028 Input changes during LO/HI have no effect; the latched values are used.
REQ-029 read_data changes only on read sampling; writes leave it unchanged.
REQ-030 read_data is updated half by half; the full 32-bit value is valid from DONE onward.

Reset
REQ-031 rst low, asynchronously: state = IDLE; counter = 0; read_data = 0; sram_addr = 0; sram_dq_out = 0; sram_dq_oe = 0; sram_we_n = 1.
REQ-032 rst asserted mid-access aborts the access immediately; sram_we_n is forced high with no glitch low; the partial write is not retried.
REQ-033 After rst is released, ready = 1 until the first request.

Verification
REQ-034 Store, WAIT_CYCLES=2: alu_res=1028, val_rm=32'hDEADBEEF -> sram_addr 2 with 16'hBEEF for 2 cycles, then sram_addr 3 with 16'hDEAD for 2 cycles; ready low for 5 cycles, high in the 6th cycle.
REQ-035 Load from alu_res=1028 after REQ-034, with an SRAM model behind the port -> read_data = 32'hDEADBEEF in DONE; ready timing matches REQ-034.
REQ-036 mem_r_en=mem_w_en=1, alu_res=1024, val_rm=32'h12345678 -> write cycle (sram_we_n toggles); read_data unchanged.
REQ-037 alu_res changed to 2048 during the LO phase of an access to 1032 -> sram_addr stays 4 then 5.
REQ-038 rst pulsed low during HI of a store -> sram_we_n = 1 and sram_dq_oe = 0 within the same cycle, all outputs at reset values, next request starts a clean LO.
REQ-039 Back-to-back loads held high across DONE -> second access begins in the IDLE cycle after DONE; no request is lost or duplicated.
